// File: rtl/mgmt_master_pkg.sv
// mgmt_master_pkg: shared constants, state encodings and command type for the mgmt bus initiator
package mgmt_master_pkg;
    localparam int MGMT_TIMEOUT = 16;
    localparam int MGMT_CNT_W = 5;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ = 2'd1;
    localparam logic [1:0] ST_GAP = 2'd2;
    typedef struct packed {
        logic [31:0] adr;
        logic rwn;
        logic [1:0] wen;
        logic [31:0] wdata;
    } cmd_t;
endpackage

// File: rtl/mgmt_master_if.sv
// mgmt_master_if: SRU command/response channel plus the mgmt bus signals
interface mgmt_master_if;
    logic cmd_valid;
    logic cmd_ready;
    logic [31:0] cmd_adr;
    logic cmd_rwn;
    logic [1:0] cmd_wen;
    logic [31:0] cmd_wdata;
    logic rsp_valid;
    logic [31:0] rsp_rdata;
    logic rsp_err;
    logic mgmt_req;
    logic [31:0] mgmt_adr;
    logic mgmt_rwn;
    logic [1:0] mgmt_wen;
    logic [31:0] mgmt_txd;
    logic mgmt_ack;
    logic mgmt_rxe;
    logic [31:0] mgmt_rxd;
    modport master (
        input cmd_valid, cmd_adr, cmd_rwn, cmd_wen, cmd_wdata, mgmt_ack, mgmt_rxe, mgmt_rxd,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd
    );
    modport slave (
        output cmd_valid, cmd_adr, cmd_rwn, cmd_wen, cmd_wdata, mgmt_ack, mgmt_rxe, mgmt_rxd,
        input cmd_ready, rsp_valid, rsp_rdata, rsp_err, mgmt_req, mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd
    );
endinterface

// File: rtl/mgmt_master.sv
// mgmt_master: mgmt bus initiator with a 1-entry command buffer, ack/timeout FSM and one-cycle gap
module mgmt_master import mgmt_master_pkg::*; #(
    parameter int TIMEOUT = MGMT_TIMEOUT,
    parameter int CNT_W = MGMT_CNT_W
) (
    input logic clk,
    input logic rst,
    mgmt_master_if.master bus
);
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
    logic pend_full;
    cmd_t pend;
    logic accept;
    logic launch;
    logic timeout;

    assign accept = bus.cmd_valid && !pend_full;
    assign launch = pend_full && state != ST_REQ;
    assign timeout = cnt == CNT_W'(TIMEOUT - 1);
    assign bus.cmd_ready = !pend_full;

    // Command buffer: captures an accepted command, frees when it moves onto the bus
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pend_full <= 1'b0;
            pend <= '0;
        end else begin
            if (accept)
                pend <= '{adr: bus.cmd_adr, rwn: bus.cmd_rwn, wen: bus.cmd_rwn ? 2'b00 : bus.cmd_wen, wdata: bus.cmd_wdata};
            pend_full <= accept || (pend_full && !launch);
        end

    // Bus FSM: launch from IDLE/GAP, wait in REQ for ack or timeout, then one idle GAP cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            bus.mgmt_req <= 1'b0;
            bus.mgmt_adr <= '0;
            bus.mgmt_rwn <= 1'b1;
            bus.mgmt_wen <= '0;
            bus.mgmt_txd <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (launch) begin
                state <= ST_REQ;
                cnt <= '0;
                bus.mgmt_req <= 1'b1;
                bus.mgmt_adr <= pend.adr;
                bus.mgmt_rwn <= pend.rwn;
                bus.mgmt_wen <= pend.wen;
                bus.mgmt_txd <= pend.wdata;
            end else if (state == ST_GAP) begin
                state <= ST_IDLE;
            end else if (state == ST_REQ) begin
                cnt <= timeout ? cnt : cnt + 1'b1;
                if (bus.mgmt_ack || timeout) begin
                    state <= ST_GAP;
                    bus.mgmt_req <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err <= !bus.mgmt_ack;
                    bus.rsp_rdata <= (bus.mgmt_ack && bus.mgmt_rxe) ? bus.mgmt_rxd : '0;
                end
            end
        end
endmodule

// File: tb/tb_mgmt_master.sv
// tb_mgmt_master: directed bench for the mgmt bus initiator with a scripted responder
module tb_mgmt_master;
    import mgmt_master_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    mgmt_master_if bus();

    mgmt_master #(.TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_t c);
        logic ok;
        ok = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_adr = c.adr;
        bus.cmd_rwn = c.rwn;
        bus.cmd_wen = c.wen;
        bus.cmd_wdata = c.wdata;
        for (int i = 0; i < 50; i++) begin
            if (bus.cmd_ready) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_req;
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bus.mgmt_req) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_rise_timeout", 32'(ok), 32'd1);
    endtask

    task automatic respond(input string tag, input cmd_t exp_bus, input int ack_at, input logic rxe,
                           input logic [31:0] rxd, input int exp_cyc, input logic exp_err,
                           input logic [31:0] exp_rdata);
        int k;
        logic stable;
        k = 0;
        stable = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            bus.mgmt_ack = (i == ack_at);
            bus.mgmt_rxe = (i == ack_at) && rxe;
            bus.mgmt_rxd = (i == ack_at) ? rxd : 32'h0;
            if (bus.mgmt_adr !== exp_bus.adr || bus.mgmt_rwn !== exp_bus.rwn ||
                bus.mgmt_wen !== exp_bus.wen || bus.mgmt_txd !== exp_bus.wdata) stable = 1'b0;
            tick;
            if (!bus.mgmt_req) begin
                k = i;
                break;
            end
        end
        bus.mgmt_ack = 1'b0;
        bus.mgmt_rxe = 1'b0;
        bus.mgmt_rxd = 32'h0;
        check({tag, "_req_cycles"}, 32'(k), 32'(exp_cyc));
        check({tag, "_bus_stable"}, 32'(stable), 32'd1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        tick;
        check({tag, "_rsp_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_gap_req_low"}, 32'(bus.mgmt_req), 32'd0);
    endtask

    initial begin
        logic quiet;
        bus.cmd_valid = 1'b0;
        bus.cmd_adr = '0;
        bus.cmd_rwn = 1'b0;
        bus.cmd_wen = '0;
        bus.cmd_wdata = '0;
        bus.mgmt_ack = 1'b0;
        bus.mgmt_rxe = 1'b0;
        bus.mgmt_rxd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_req", 32'(bus.mgmt_req), 32'd0);
        check("rst_adr", bus.mgmt_adr, 32'h0);
        check("rst_rwn", 32'(bus.mgmt_rwn), 32'd1);
        check("rst_wen", 32'(bus.mgmt_wen), 32'd0);
        check("rst_txd", bus.mgmt_txd, 32'h0);

        // read, ack with data two edges after req rises
        send('{adr: 32'h3, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        wait_req;
        respond("rd", '{adr: 32'h3, rwn: 1'b1, wen: 2'b00, wdata: 32'h0}, 3, 1'b1, 32'h1234_5678, 3, 1'b0, 32'h1234_5678);

        // write, ack without rxe: junk on rxd must not leak
        send('{adr: 32'h2, rwn: 1'b0, wen: 2'b11, wdata: 32'hDEAD_BEEF});
        wait_req;
        respond("wr", '{adr: 32'h2, rwn: 1'b0, wen: 2'b11, wdata: 32'hDEAD_BEEF}, 3, 1'b0, 32'hFFFF_FFFF, 3, 1'b0, 32'h0);

        // read with byte enables set: bus wen forced to 0
        send('{adr: 32'h44, rwn: 1'b1, wen: 2'b11, wdata: 32'h5A5A_5A5A});
        wait_req;
        respond("rdwen", '{adr: 32'h44, rwn: 1'b1, wen: 2'b00, wdata: 32'h5A5A_5A5A}, 3, 1'b1, 32'h0BAD_F00D, 3, 1'b0, 32'h0BAD_F00D);

        // no responder: timeout after 16 cycles, late ack ignored
        send('{adr: 32'h10, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        wait_req;
        respond("tmo", '{adr: 32'h10, rwn: 1'b1, wen: 2'b00, wdata: 32'h0}, 0, 1'b0, 32'h0, 16, 1'b1, 32'h0);
        tick;
        bus.mgmt_ack = 1'b1;
        bus.mgmt_rxe = 1'b1;
        bus.mgmt_rxd = 32'h5555_5555;
        tick;
        bus.mgmt_ack = 1'b0;
        bus.mgmt_rxe = 1'b0;
        bus.mgmt_rxd = 32'h0;
        check("stale_ack_no_rsp", 32'(bus.rsp_valid), 32'd0);
        tick;
        check("stale_ack_no_rsp2", 32'(bus.rsp_valid), 32'd0);
        check("stale_ack_no_req", 32'(bus.mgmt_req), 32'd0);

        // back-to-back: second command posted during the first request
        send('{adr: 32'hA0, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        wait_req;
        send('{adr: 32'hB0, rwn: 1'b0, wen: 2'b01, wdata: 32'hCAFE_0001});
        check("b2b_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("b2b_first_adr", bus.mgmt_adr, 32'hA0);
        tick;
        bus.mgmt_ack = 1'b1;
        bus.mgmt_rxe = 1'b1;
        bus.mgmt_rxd = 32'hAAAA_0001;
        tick;
        bus.mgmt_ack = 1'b0;
        bus.mgmt_rxe = 1'b0;
        bus.mgmt_rxd = 32'h0;
        check("b2b_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b_rsp1_rdata", bus.rsp_rdata, 32'hAAAA_0001);
        check("b2b_gap_req", 32'(bus.mgmt_req), 32'd0);
        check("b2b_gap_ready", 32'(bus.cmd_ready), 32'd0);
        tick;
        check("b2b_launch_req", 32'(bus.mgmt_req), 32'd1);
        check("b2b_launch_ready", 32'(bus.cmd_ready), 32'd1);
        check("b2b_launch_rsp", 32'(bus.rsp_valid), 32'd0);
        respond("b2b2", '{adr: 32'hB0, rwn: 1'b0, wen: 2'b01, wdata: 32'hCAFE_0001}, 3, 1'b0, 32'h0, 3, 1'b0, 32'h0);

        // reset while request is active and buffer holds another command
        send('{adr: 32'hC0, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        wait_req;
        send('{adr: 32'hD0, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        check("rstmid_buf_full", 32'(bus.cmd_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rstmid_req_async", 32'(bus.mgmt_req), 32'd0);
        check("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
        check("rstmid_rsp", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bus.mgmt_req || bus.rsp_valid) quiet = 1'b0;
        end
        check("rstmid_discard", 32'(quiet), 32'd1);

        // ack arriving on the timeout cycle wins
        send('{adr: 32'hE0, rwn: 1'b1, wen: 2'b00, wdata: 32'h0});
        wait_req;
        respond("ackedge", '{adr: 32'hE0, rwn: 1'b1, wen: 2'b00, wdata: 32'h0}, 16, 1'b1, 32'h7777_8888, 16, 1'b0, 32'h7777_8888);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
